// File: rtl/cache_arbiter_if.sv
// Bus bundle for cache_arbiter: icache/dcache line-miss ports and the physical-memory line port.
// slave is the arbiter's view; master is the view of whatever drives the caches and memory.
interface cache_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// Serialises icache/dcache line transactions onto one memory line port, one whole line at a time.
// Define CACHE_ARBITER_RR_EN for round-robin grant; otherwise dcache has fixed priority.
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic           clk,
  input  logic           rst,
  cache_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_write;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;

  logic w_idle;
  logic w_d_req;
  logic w_d_pri;
  logic w_grant_d;
  logic w_grant_i;
  logic w_pmem_read;
  logic w_pmem_write;
  logic w_i_resp;
  logic w_d_resp;

  assign w_idle  = (r_state == IDLE);
  assign w_d_req = bus.d_read | bus.d_write;

`ifdef CACHE_ARBITER_RR_EN
  // Last-served flag starts at icache so the first contention goes to dcache.
  logic r_last_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_i <= 1'b1;
    end else if (w_grant_i || w_grant_d) begin
      r_last_i <= w_grant_i;
    end
  end

  assign w_d_pri = r_last_i;
`else
  assign w_d_pri = 1'b1;
`endif

  assign w_grant_d = w_idle && w_d_req && (!bus.i_read || w_d_pri);
  assign w_grant_i = w_idle && bus.i_read && !w_grant_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_next = SERVE_D;
        end else if (w_grant_i) begin
          w_next = SERVE_I;
        end
      end
      SERVE_I: if (bus.pmem_resp) w_next = RESP_I;
      SERVE_D: if (bus.pmem_resp) w_next = RESP_D;
      RESP_I:  w_next = IDLE;
      RESP_D:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_pmem_read  = 1'b0;
    w_pmem_write = 1'b0;
    w_i_resp     = 1'b0;
    w_d_resp     = 1'b0;
    unique case (r_state)
      SERVE_I: w_pmem_read = 1'b1;
      SERVE_D: begin
        w_pmem_read  = !r_write;
        w_pmem_write = r_write;
      end
      RESP_I:  w_i_resp = 1'b1;
      RESP_D:  w_d_resp = 1'b1;
      default: ;
    endcase
  end

  // Read+write together from dcache is taken as a write-back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_grant_d) begin
        r_addr  <= bus.d_addr;
        r_wdata <= bus.d_wdata;
        r_write <= bus.d_write;
      end else if (w_grant_i) begin
        r_addr  <= bus.i_addr;
        r_wdata <= '0;
        r_write <= 1'b0;
      end
      if (r_state == SERVE_I && bus.pmem_resp) begin
        r_i_rdata <= bus.pmem_rdata;
      end
      if (r_state == SERVE_D && bus.pmem_resp && !r_write) begin
        r_d_rdata <= bus.pmem_rdata;
      end
    end
  end

  assign bus.pmem_read  = w_pmem_read;
  assign bus.pmem_write = w_pmem_write;
  assign bus.pmem_addr  = r_addr;
  assign bus.pmem_wdata = r_wdata;
  assign bus.i_resp     = w_i_resp;
  assign bus.d_resp     = w_d_resp;
  assign bus.i_rdata    = r_i_rdata;
  assign bus.d_rdata    = r_d_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: expected memory transactions and responses are queued at
// request time and checked as the memory port and the cache response ports show them.
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } mem_t;

  typedef struct {
    logic          is_d;
    logic [LW-1:0] data;
  } rsp_t;

  mem_t q_mem[$];
  rsp_t q_rsp[$];

  int            n_vec   = 0;
  int            n_err   = 0;
  logic [LW-1:0] exp_i   = '0;
  logic [LW-1:0] exp_d   = '0;
  logic          last_i  = 1'b1;
  int            mem_lat = 0;
  int            mem_cnt = 0;
  bit            stray   = 1'b0;
  mem_t          cur;
  bit            cur_v   = 1'b0;
  bit            prev_rsp = 1'b0;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] mk(input logic [AW-1:0] a);
    return {8{a ^ 32'hDEADBE8F}};
  endfunction

  // memory: answers a held strobe after mem_lat extra cycles
  always @(negedge clk) begin
    bus.pmem_resp = stray;
    if (bus.pmem_read === 1'b1 || bus.pmem_write === 1'b1) begin
      if (mem_cnt == mem_lat) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = mk(bus.pmem_addr);
        mem_cnt = 0;
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
      bus.pmem_rdata = '0;
    end
  end

  // memory-side monitor
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.pmem_read || bus.pmem_write) begin
        chk("pmem_excl", LW'(bus.pmem_read & bus.pmem_write), LW'(0));
        if (!cur_v) begin
          if (q_mem.size() == 0) chk("pmem_unexp", LW'(1), LW'(0));
          else begin
            cur   = q_mem.pop_front();
            cur_v = 1'b1;
          end
        end
        if (cur_v) begin
          chk("pmem_write", LW'(bus.pmem_write), LW'(cur.wr));
          chk("pmem_read", LW'(bus.pmem_read), LW'(!cur.wr));
          chk("pmem_addr", LW'(bus.pmem_addr), LW'(cur.addr));
          if (cur.wr) chk("pmem_wdata", bus.pmem_wdata, cur.wdata);
        end
      end else begin
        cur_v = 1'b0;
      end
    end else begin
      cur_v = 1'b0;
    end
  end

  // cache-side response monitor
  always @(negedge clk) begin
    rsp_t r;
    if (rst === 1'b1) begin
      if (bus.i_resp || bus.d_resp) begin
        chk("resp_excl", LW'(bus.i_resp & bus.d_resp), LW'(0));
        chk("resp_pulse", LW'(prev_rsp), LW'(0));
        if (q_rsp.size() == 0) chk("resp_unexp", LW'(1), LW'(0));
        else begin
          r = q_rsp.pop_front();
          chk("resp_src", LW'(bus.d_resp), LW'(r.is_d));
          if (r.is_d) chk("d_rdata", bus.d_rdata, r.data);
          else        chk("i_rdata", bus.i_rdata, r.data);
        end
      end
      prev_rsp = bus.i_resp | bus.d_resp;
    end else begin
      prev_rsp = 1'b0;
    end
  end

  task automatic push_i(input logic [AW-1:0] a);
    rsp_t r;
    q_mem.push_back('{wr: 1'b0, addr: a, wdata: '0});
    exp_i  = mk(a);
    r.is_d = 1'b1;
    r.is_d = 1'b0;
    r.data = exp_i;
    q_rsp.push_back(r);
    last_i = 1'b1;
  endtask

  task automatic push_d(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
    rsp_t r;
    q_mem.push_back('{wr: wr, addr: a, wdata: wd});
    if (!wr) exp_d = mk(a);
    r.is_d = 1'b1;
    r.data = exp_d;
    q_rsp.push_back(r);
    last_i = 1'b0;
  endtask

  task automatic issue(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit dw,
                       input logic [AW-1:0] da, input logic [LW-1:0] dwd);
    bit d_first;
`ifdef CACHE_ARBITER_RR_EN
    d_first = last_i;
`else
    d_first = 1'b1;
`endif
    if (ir && (dr || dw)) begin
      if (d_first) begin push_d(dw, da, dwd); push_i(ia); end
      else         begin push_i(ia); push_d(dw, da, dwd); end
    end else if (ir) push_i(ia);
    else if (dr || dw) push_d(dw, da, dwd);
    bus.i_read  = ir;
    bus.i_addr  = ia;
    bus.d_read  = dr;
    bus.d_write = dw;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
  endtask

  task automatic wait_done(input int budget, input bit poke);
    int n;
    n = 0;
    while ((bus.i_read || bus.d_read || bus.d_write) && n < budget) begin
      @(negedge clk);
      n++;
      if (bus.i_resp) bus.i_read = 1'b0;
      if (bus.d_resp) begin
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
      end
      if (poke && n == 2) begin
        bus.d_addr  = 32'hFFFF_FFC0;
        bus.d_wdata = '1;
      end
    end
    chk("timeout", LW'(bus.i_read | bus.d_read | bus.d_write), LW'(0));
    repeat (2) @(negedge clk);
    chk("mem_q_empty", LW'(q_mem.size()), LW'(0));
    chk("rsp_q_empty", LW'(q_rsp.size()), LW'(0));
    chk("i_rdata_hold", bus.i_rdata, exp_i);
    chk("d_rdata_hold", bus.d_rdata, exp_d);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pread"}, LW'(bus.pmem_read), LW'(0));
    chk({tag, "_pwrite"}, LW'(bus.pmem_write), LW'(0));
    chk({tag, "_paddr"}, LW'(bus.pmem_addr), LW'(0));
    chk({tag, "_pwdata"}, bus.pmem_wdata, LW'(0));
    chk({tag, "_irdata"}, bus.i_rdata, LW'(0));
    chk({tag, "_drdata"}, bus.d_rdata, LW'(0));
    chk({tag, "_iresp"}, LW'(bus.i_resp), LW'(0));
    chk({tag, "_dresp"}, LW'(bus.d_resp), LW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    bus.i_read = 1'b0; bus.i_addr = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // lone icache fill: strobe in the cycle after the grant edge
    mem_lat = 3;
    issue(1'b1, 32'h0000_0060, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("i_strobe_n1", LW'(bus.pmem_read), LW'(1));
    wait_done(60, 1'b0);
    chk("i_fill_data", bus.i_rdata, {8{32'hDEADBEEF}});

    // dcache write-back, address change mid-transaction ignored
    mem_lat = 4;
    issue(1'b0, '0, 1'b0, 1'b1, 32'h0000_1000, {32{8'hA5}});
    wait_done(60, 1'b1);

    // dcache read then illegal read+write taken as write
    mem_lat = 1;
    issue(1'b0, '0, 1'b1, 1'b0, 32'h0000_2040, '0);
    wait_done(60, 1'b0);
    issue(1'b0, '0, 1'b1, 1'b1, 32'h0000_3000, {8{32'h1234_5678}});
    wait_done(60, 1'b0);

    // minimum latency: memory answers in the first serve cycle
    mem_lat = 0;
    issue(1'b1, 32'h0000_0100, 1'b0, 1'b0, '0, '0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.i_resp && n < 10);
    chk("min_lat", LW'(n), LW'(2));
    bus.i_read = 1'b0;
    wait_done(60, 1'b0);

    // contentions: two with loser held, lone dcache, then one more
    mem_lat = 2;
    issue(1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'h0000_0400, '0);
    wait_done(80, 1'b0);
    issue(1'b1, 32'h0000_0220, 1'b1, 1'b0, 32'h0000_0420, '0);
    wait_done(80, 1'b0);
    issue(1'b0, '0, 1'b1, 1'b0, 32'h0000_0440, '0);
    wait_done(80, 1'b0);
    issue(1'b1, 32'h0000_0240, 1'b1, 1'b0, 32'h0000_0460, '0);
    wait_done(80, 1'b0);

    // stray memory response while idle
    @(posedge clk); stray = 1'b1;
    @(posedge clk); stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stray_idle", LW'(bus.pmem_read | bus.pmem_write | bus.i_resp | bus.d_resp), LW'(0));
    end

    // asynchronous reset during an icache fill
    mem_lat = 20;
    issue(1'b1, 32'h0000_0500, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_zero("mid_reset");
    bus.i_read = 1'b0;
    q_mem.delete();
    q_rsp.delete();
    exp_i  = '0;
    exp_d  = '0;
    last_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_abandoned_resp", LW'(bus.i_resp | bus.d_resp), LW'(0));
    end
    mem_lat = 1;
    issue(1'b1, 32'h0000_0520, 1'b0, 1'b0, '0, '0);
    wait_done(60, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
